// File: rtl/ring_resp_pkg.sv
// Shared definitions for the ring responder: state encoding, default
// parameters and small state-classification helpers.
package ring_resp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_READY = 3'd2,
      ST_ACK   = 3'd3,
      ST_DONE  = 3'd4,
      ST_FAIL  = 3'd5
   } state_e;

   localparam int K_DEF         = 32;
   localparam int MAX_WAIT_DEF  = 8;
   localparam int MAX_LOSS_DEF  = 3;
   localparam int MAX_RETRY_DEF = 2;

   // DONE and FAIL only leave on reset
   function automatic logic is_sticky(state_e s);
      return (s == ST_DONE) || (s == ST_FAIL);
   endfunction

   // An ack decision is only legal while the token waits at the responder
   function automatic logic ack_forbidden(state_e s);
      return (s == ST_IDLE) || (s == ST_RECV) || (s == ST_ACK);
   endfunction

endpackage

// File: rtl/ring_hop_ctr.sv
// Hop position counter for a token on the ring. Clear wins over
// everything; hold stalls an increment; the count saturates at K-1.
module ring_hop_ctr #(
   parameter  int K  = 32,
   localparam int HW = $clog2(K)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          hold,
   input  logic          inc,
   output logic [HW-1:0] hop,
   output logic          at_last
);

   localparam logic [HW-1:0] HOP_MAX = HW'(K - 1);
   localparam logic [HW-1:0] HOP_PEN = HW'(K - 2);

   logic [HW-1:0] hop_q;
   logic [HW-1:0] hop_d;

   // Next hop value: clear, else saturating stall-able increment
   always_comb begin
      hop_d = hop_q;
      if (clr) begin
         hop_d = '0;
      end else if (inc && !hold && (hop_q != HOP_MAX)) begin
         hop_d = hop_q + 1'b1;
      end
   end

   // Hop register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hop_q <= '0;
      end else begin
         hop_q <= hop_d;
      end
   end

   assign hop     = hop_q;
   assign at_last = (hop_q == HOP_PEN);

endmodule

// File: rtl/ring_resp.sv
// Responder end of the ring request protocol: follows the request token
// to the responder, waits for the ack decision, then follows the ack
// back around the ring with loss-triggered retransmission.
module ring_resp
   import ring_resp_pkg::*;
#(
   parameter  int K         = K_DEF,
   parameter  int MAX_WAIT  = MAX_WAIT_DEF,
   parameter  int MAX_LOSS  = MAX_LOSS_DEF,
   parameter  int MAX_RETRY = MAX_RETRY_DEF,
   localparam int HW        = $clog2(K)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_in,
   input  logic          loss,
   input  logic          abort,
   input  logic          controllable_ack,
   output logic          ack_out,
   output logic [HW-1:0] hop,
   output logic          error,
   output logic          objective
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int LW = $clog2(MAX_LOSS + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);

   localparam logic [WW-1:0] WAIT_LIM  = WW'(MAX_WAIT);
   localparam logic [LW-1:0] LOSS_LIM  = LW'(MAX_LOSS);
   localparam logic [LW-1:0] LOSS_PRE  = LW'(MAX_LOSS - 1);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

   state_e        state_q, state_d;
   logic [WW-1:0] wait_q,  wait_d;
   logic [LW-1:0] loss_q,  loss_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          ack_q,   ack_d;

   logic hop_clr;
   logic hop_inc;
   logic hop_at_last;

   ring_hop_ctr #(.K(K)) u_hop (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (hop_clr),
      .hold    (loss),
      .inc     (hop_inc),
      .hop     (hop),
      .at_last (hop_at_last)
   );

   // State and counter registers; ack_out is registered so it only moves on the edge
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
         loss_q  <= '0;
         retry_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         loss_q  <= loss_d;
         retry_q <= retry_d;
         ack_q   <= ack_d;
      end
   end

   // Next state: sticky > premature ack > abort > per-state advance/loss handling
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      loss_d  = loss_q;
      retry_d = retry_q;
      ack_d   = 1'b0;
      hop_clr = 1'b0;
      hop_inc = 1'b0;
      if (is_sticky(state_q)) begin
         state_d = state_q;
      end else if (controllable_ack && ack_forbidden(state_q)) begin
         state_d = ST_FAIL;
      end else if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         hop_clr = 1'b1;
         wait_d  = '0;
         loss_d  = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_in && !loss) begin
                  state_d = ST_RECV;
                  hop_inc = 1'b1;
               end
            end
            ST_RECV: begin
               if (!loss) begin
                  hop_inc = 1'b1;
                  if (hop_at_last) state_d = ST_READY;
               end
            end
            ST_READY: begin
               // loss has no effect here: the token is parked at the responder
               if (controllable_ack) begin
                  state_d = ST_ACK;
                  hop_clr = 1'b1;
                  ack_d   = 1'b1;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_q + 1'b1;
                  if (wait_d == WAIT_LIM) state_d = ST_FAIL;
               end
            end
            ST_ACK: begin
               if (!loss) begin
                  hop_inc = 1'b1;
                  loss_d  = '0;
                  if (hop_at_last) state_d = ST_DONE;
               end else if (loss_q == LOSS_PRE) begin
                  if (retry_q == RETRY_LIM) begin
                     state_d = ST_FAIL;
                     loss_d  = LOSS_LIM;
                  end else begin
                     hop_clr = 1'b1;
                     loss_d  = '0;
                     retry_d = retry_q + 1'b1;
                     ack_d   = 1'b1;
                  end
               end else begin
                  loss_d = loss_q + 1'b1;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Outputs decode registered state only
   always_comb begin
      ack_out   = ack_q;
      error     = (state_q == ST_FAIL);
      objective = (state_q == ST_DONE);
   end

endmodule
